// File: rtl/gb_serial_pkg.sv
// Shared definitions for the Game Boy link-port serial transceiver.
package gb_serial_pkg;

  localparam logic [15:0] SB_ADDR_DEFAULT = 16'hFF01;
  localparam logic [15:0] SC_ADDR_DEFAULT = 16'hFF02;

  // SC register bit positions
  localparam int SC_START  = 7;
  localparam int SC_CLKSEL = 0;

  // Interrupt flag bit owned by this block
  localparam int IRQ_SERIAL = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // SC read value: unused bits read as ones
  function automatic logic [7:0] sc_pack(input logic start, input logic clksel);
    return {start, 6'b111111, clksel};
  endfunction

endpackage

// File: rtl/gb_serial_if.sv
// CPU-side bus of the serial transceiver: register access plus interrupt request/ack.
interface gb_serial_if;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic [7:0]  data;
  logic        hit;
  logic [7:0]  iack;
  logic        irq;

  modport master (
    output addr, data_in, we, iack,
    input  data, hit, irq
  );

  modport slave (
    input  addr, data_in, we, iack,
    output data, hit, irq
  );
endinterface

// File: rtl/gb_sync_edge.sv
// Two-flop synchronizer for an asynchronous input, followed by a history flop
// that yields one-cycle rise/fall pulses (3 clk cycles from pin edge to action).
module gb_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronize the pin and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
      prev_r <= RESET_VAL;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/gb_serial.sv
// Game Boy link-port serial transceiver: SB/SC registers, 8-bit shift with
// internal or external serial clock, and the serial interrupt request.
module gb_serial
  import gb_serial_pkg::*;
#(
  parameter int          HALF_PERIOD = 256,
  parameter logic [15:0] SB_ADDR     = SB_ADDR_DEFAULT,
  parameter logic [15:0] SC_ADDR     = SC_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        resetn,
  gb_serial_if.slave  bus,
  input  logic        sin,
  output logic        sout,
  input  logic        sclk_in,
  output logic        sclk_out,
  output logic        sclk_oe
);

  localparam int              HP_W    = $clog2(HALF_PERIOD);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

  state_t          state_r;
  logic [7:0]      sb_r;
  logic            start_r;
  logic            clksel_r;
  logic            sout_r;
  logic            sclk_out_r;
  logic            irq_r;
  logic [2:0]      bit_cnt_r;
  logic [HP_W-1:0] hp_cnt_r;

  logic       sb_hit_s;
  logic       sc_hit_s;
  logic       wr_sb_s;
  logic       wr_sc_s;
  logic       abort_s;
  logic       tick_s;
  logic       ser_fall_s;
  logic       ser_rise_s;
  logic       done_s;
  logic       ext_rise_s;
  logic       ext_fall_s;
  logic [7:0] rdata_s;

  gb_sync_edge #(
    .RESET_VAL (1'b1)
  ) u_sclk_sync (
    .clk      (clk),
    .resetn   (resetn),
    .async_in (sclk_in),
    .rise     (ext_rise_s),
    .fall     (ext_fall_s)
  );

  // Address decode, read mux and serial-clock edge selection
  always_comb begin
    sb_hit_s   = (bus.addr == SB_ADDR);
    sc_hit_s   = (bus.addr == SC_ADDR);
    wr_sb_s    = bus.we & sb_hit_s;
    wr_sc_s    = bus.we & sc_hit_s;
    abort_s    = (state_r == SHIFT) & wr_sc_s & ~bus.data_in[SC_START];
    tick_s     = (state_r == SHIFT) & clksel_r & (hp_cnt_r == HP_LAST);
    ser_fall_s = 1'b0;
    ser_rise_s = 1'b0;
    rdata_s    = 8'hFF;
    if (state_r == SHIFT) begin
      if (clksel_r) begin
        ser_fall_s = tick_s & sclk_out_r;
        ser_rise_s = tick_s & ~sclk_out_r;
      end else begin
        ser_fall_s = ext_fall_s;
        ser_rise_s = ext_rise_s;
      end
    end else begin
      ser_fall_s = 1'b0;
      ser_rise_s = 1'b0;
    end
    done_s = ser_rise_s & ~abort_s & (bit_cnt_r == 3'd7);
    if (sb_hit_s) begin
      rdata_s = sb_r;
    end else if (sc_hit_s) begin
      rdata_s = sc_pack(start_r, clksel_r);
    end else begin
      rdata_s = 8'hFF;
    end
  end

  // Register file, transfer state machine, serial clock and interrupt request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= IDLE;
      sb_r       <= 8'h00;
      start_r    <= 1'b0;
      clksel_r   <= 1'b0;
      sout_r     <= 1'b1;
      sclk_out_r <= 1'b1;
      irq_r      <= 1'b0;
      bit_cnt_r  <= 3'd0;
      hp_cnt_r   <= {HP_W{1'b0}};
    end else begin
      // Completion beats a simultaneous acknowledge
      if (done_s) begin
        irq_r <= 1'b1;
      end else if (bus.iack[IRQ_SERIAL]) begin
        irq_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          sclk_out_r <= 1'b1;
          if (wr_sb_s) begin
            sb_r <= bus.data_in;
          end
          if (wr_sc_s) begin
            clksel_r <= bus.data_in[SC_CLKSEL];
            if (bus.data_in[SC_START]) begin
              start_r   <= 1'b1;
              bit_cnt_r <= 3'd0;
              hp_cnt_r  <= {HP_W{1'b0}};
              state_r   <= SHIFT;
            end
          end
        end

        SHIFT: begin
          if (abort_s) begin
            // Partial SB contents are kept; no interrupt
            clksel_r   <= bus.data_in[SC_CLKSEL];
            start_r    <= 1'b0;
            sclk_out_r <= 1'b1;
            state_r    <= IDLE;
          end else begin
            if (clksel_r) begin
              hp_cnt_r <= tick_s ? {HP_W{1'b0}} : (hp_cnt_r + HP_W'(1'b1));
            end
            if (tick_s) begin
              sclk_out_r <= ~sclk_out_r;
            end
            if (ser_fall_s) begin
              sout_r <= sb_r[7];
            end
            if (ser_rise_s) begin
              sb_r      <= {sb_r[6:0], sin};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                start_r    <= 1'b0;
                sclk_out_r <= 1'b1;
                state_r    <= IDLE;
              end
            end
          end
        end

        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.data = rdata_s;
  assign bus.hit  = sb_hit_s | sc_hit_s;
  assign bus.irq  = irq_r;
  assign sout     = sout_r;
  assign sclk_out = sclk_out_r;
  assign sclk_oe  = clksel_r;

endmodule

// File: tb/tb_gb_serial.sv
// Directed self-checking bench for gb_serial with HALF_PERIOD=4.
module tb_gb_serial;

  logic clk;
  logic resetn;
  logic sin;
  logic sout;
  logic sclk_in;
  logic sclk_out;
  logic sclk_oe;
  logic loop_en;
  logic sin_val;

  int checks = 0;
  int errors = 0;

  gb_serial_if bus ();

  gb_serial #(
    .HALF_PERIOD (4),
    .SB_ADDR     (16'hFF01),
    .SC_ADDR     (16'hFF02)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .sin      (sin),
    .sout     (sout),
    .sclk_in  (sclk_in),
    .sclk_out (sclk_out),
    .sclk_oe  (sclk_oe)
  );

  assign sin = loop_en ? sout : sin_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    bus.addr = a;
    #1;
    check(tag, bus.data, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.addr    = a;
    bus.data_in = d;
    bus.we      = 1'b1;
    @(negedge clk);
    bus.we      = 1'b0;
  endtask

  task automatic pulse_iack(input logic [7:0] v);
    bus.iack = v;
    @(negedge clk);
    bus.iack = 8'h00;
  endtask

  logic [7:0] got;
  logic [7:0] exp_bits;
  logic       prev_sclk;
  int         nf;

  initial begin
    resetn      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 8'h00;
    bus.we      = 1'b0;
    bus.iack    = 8'h00;
    loop_en     = 1'b0;
    sin_val     = 1'b1;
    sclk_in     = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    rd(16'hFF01, 8'h00, "rst_sb");
    check("rst_sb_hit", {7'd0, bus.hit}, 8'h01);
    rd(16'hFF02, 8'h7E, "rst_sc");
    check("rst_sout", {7'd0, sout}, 8'h01);
    check("rst_sclk_out", {7'd0, sclk_out}, 8'h01);
    check("rst_irq", {7'd0, bus.irq}, 8'h00);
    check("rst_sclk_oe", {7'd0, sclk_oe}, 8'h00);
    rd(16'hFF03, 8'hFF, "miss_data");
    check("miss_hit", {7'd0, bus.hit}, 8'h00);

    // Internal-clock loopback of 8'hA5
    loop_en = 1'b1;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    got       = 8'h00;
    nf        = 0;
    prev_sclk = sclk_out;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (prev_sclk && !sclk_out) begin
        if (nf < 8) got[7 - nf] = sout;
        nf++;
      end
      prev_sclk = sclk_out;
      if (i == 63) check("lb_irq_early", {7'd0, bus.irq}, 8'h00);
    end
    check("lb_irq", {7'd0, bus.irq}, 8'h01);
    check("lb_falls", 8'(nf), 8'd8);
    check("lb_sout_bits", got, 8'hA5);
    rd(16'hFF01, 8'hA5, "lb_sb");
    rd(16'hFF02, 8'h7F, "lb_sc");
    check("lb_sclk_idle", {7'd0, sclk_out}, 8'h01);

    // Acknowledge behaviour
    pulse_iack(8'h04);
    check("iack_other_bit", {7'd0, bus.irq}, 8'h01);
    pulse_iack(8'h08);
    check("iack_clear", {7'd0, bus.irq}, 8'h00);

    // Ack in the completion cycle: set wins
    wr(16'hFF02, 8'h81);
    repeat (63) @(negedge clk);
    check("race_pre", {7'd0, bus.irq}, 8'h00);
    bus.iack = 8'h08;
    @(negedge clk);
    bus.iack = 8'h00;
    check("race_irq", {7'd0, bus.irq}, 8'h01);
    rd(16'hFF02, 8'h7F, "race_sc");
    pulse_iack(8'h08);
    check("race_clear", {7'd0, bus.irq}, 8'h00);

    // Abort after 3 bits, during the low phase of bit 4
    wr(16'hFF01, 8'hC3);
    wr(16'hFF02, 8'h81);
    repeat (29) @(negedge clk);
    check("mid_low", {7'd0, sclk_out}, 8'h00);
    wr(16'hFF02, 8'h01);
    check("mid_sclk", {7'd0, sclk_out}, 8'h01);
    rd(16'hFF02, 8'h7F, "mid_sc");
    rd(16'hFF01, 8'h1E, "mid_sb_partial");
    repeat (40) @(negedge clk);
    check("mid_no_irq", {7'd0, bus.irq}, 8'h00);
    check("mid_sclk_hold", {7'd0, sclk_out}, 8'h01);
    wr(16'hFF01, 8'h12);
    rd(16'hFF01, 8'h12, "mid_sb_write");

    // External clock, sin tied high
    loop_en = 1'b0;
    sin_val = 1'b1;
    wr(16'hFF01, 8'h3C);
    wr(16'hFF02, 8'h80);
    wr(16'hFF01, 8'h55);
    check("ext_oe", {7'd0, sclk_oe}, 8'h00);
    rd(16'hFF02, 8'hFE, "ext_sc_busy");
    exp_bits = 8'h3C;
    for (int b = 0; b < 8; b++) begin
      sclk_in = 1'b0;
      repeat (10) @(negedge clk);
      check($sformatf("ext_sout_%0d", b), {7'd0, sout}, {7'd0, exp_bits[7 - b]});
      if (b == 7) check("ext_irq_early", {7'd0, bus.irq}, 8'h00);
      sclk_in = 1'b1;
      repeat (10) @(negedge clk);
    end
    rd(16'hFF01, 8'hFF, "ext_sb");
    check("ext_irq", {7'd0, bus.irq}, 8'h01);
    check("ext_oe_end", {7'd0, sclk_oe}, 8'h00);
    rd(16'hFF02, 8'h7E, "ext_sc_done");

    // Asynchronous reset during bit 5
    loop_en = 1'b1;
    wr(16'hFF01, 8'hA5);
    wr(16'hFF02, 8'h81);
    repeat (38) @(negedge clk);
    check("ar_pre_sclk", {7'd0, sclk_out}, 8'h00);
    check("ar_pre_sout", {7'd0, sout}, 8'h00);
    #1;
    resetn = 1'b0;
    #1;
    check("ar_sout", {7'd0, sout}, 8'h01);
    check("ar_sclk_out", {7'd0, sclk_out}, 8'h01);
    check("ar_irq", {7'd0, bus.irq}, 8'h00);
    check("ar_sclk_oe", {7'd0, sclk_oe}, 8'h00);
    rd(16'hFF01, 8'h00, "ar_sb");
    rd(16'hFF02, 8'h7E, "ar_sc");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_serial.md
# gb_serial

Game Boy link-port serial transceiver: responds to CPU bus accesses at SB (FF01) and SC (FF02), shifts one byte out on `sout` while shifting one in from `sin`, and raises the serial interrupt (IF bit 3) on completion. Sits beside the MMU on the CPU data bus. The CPU acts as bus initiator and interrupt acknowledger; this block is the responder on both. Supports internal clocking (drives `sclk_out`) and external clocking (follows `sclk_in`).

## Interface
- `HALF_PERIOD`, 256: `clk` cycles per internal serial-clock half period. 256 gives 8192 Hz at 4.194304 MHz. Minimum 2.
- `SB_ADDR`, 16'hFF01: serial data register address.
- `SC_ADDR`, 16'hFF02: serial control register address.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `addr`  in  16  CPU address.
- `data_in`  in  8  CPU write data.
- `we`  in  1  CPU write strobe, one cycle per write.
- `data`  out  8  read data, combinational from `addr`; 8'hFF when `hit`=0.
- `hit`  out  1  `addr` equals SB_ADDR or SC_ADDR.
- `iack`  in  8  interrupt acknowledge; bit 3 clears the request.
- `irq`  out  1  serial interrupt request (level); feeds `iflags[3]`.
- `sin`  in  1  serial data in.
- `sout`  out  1  serial data out.
- `sclk_in`  in  1  external serial clock, asynchronous.
- `sclk_out`  out  1  internal serial clock.
- `sclk_oe`  out  1  high while internal clock selected.

## Operation
- Registers:
  - SB[7:0] is the shift register.
  - SC reads {start, 6'b111111, clksel}.
- Reset values: SB=0, start=0, clksel=0, `sclk_out`=1, `sout`=1, `irq`=0, bit count=0, state IDLE. `sclk_oe` equals clksel.
- States: IDLE, SHIFT.
- In IDLE:
  - A write to SB loads SB.
  - A write to SC loads clksel. If `data_in[7]`=1, the block sets start, clears the bit count and half-period counter, and enters SHIFT.
- In SHIFT, each serial clock:
  - Falling edge: `sout` <= SB[7].
  - Rising edge: SB <= {SB[6:0], `sin`} and the bit count increments.
  - After the 8th rising edge: start<=0, `irq`<=1, state IDLE, `sclk_out`=1.
- Clock source: the internal clock toggles `sclk_out` every HALF_PERIOD cycles, starting high. The external clock uses `sclk_in` through a 2-flop synchronizer plus edge detector.
- In SHIFT:
  - Writes to SB are ignored.
  - A write to SC with bit7=0 aborts the transfer: state IDLE, start=0, `sclk_out`=1, SB keeps its partial contents, no `irq`.
  - A write to SC with bit7=1 is ignored.
- `irq`:
  - Clears on `iack[3]`=1.
  - If completion and `iack[3]` occur in the same cycle, set wins.
  - `iack` bits other than bit 3 are ignored.
- Reads have no side effects.

## Timing
- Internal clock, with SC start write at edge 0:
  - `sclk_out` falls at edge HALF_PERIOD and rises at 2·HALF_PERIOD.
  - The 8th rise is at 16·HALF_PERIOD.
  - `irq`=1 and start=0 are visible after edge 16·HALF_PERIOD.
- External clock:
  - Edge-to-action latency is 3 `clk` cycles (2 sync, 1 detect).
  - `sclk_in` pulses narrower than 2 `clk` cycles are not guaranteed to be seen.
  - Transfer duration is set by the partner device.
- Bus read data is valid in the same cycle as `addr`. A write takes effect at the rising edge where `we`=1.
- Asynchronous reset mid-transfer forces all reset values immediately. The transfer is lost.

## Structure
- Package `gb_serial_pkg`:
  - SB/SC address localparams.
  - SC bit positions (START=7, CLKSEL=0).
  - IRQ_SERIAL=3.
  - State enum {IDLE, SHIFT}.
- Sub-module `gb_sync_edge`: 2-flop synchronizer with rise/fall pulse outputs. The timer block will reuse it for external inputs.
- Top level holds the registers, the state machine, the half-period counter and the 3-bit bit counter.

## Test plan
All scenarios use HALF_PERIOD=4.
- Reset, then read FF01 and FF02 -> `data`=8'h00 and 8'h7E. `sout`=1, `sclk_out`=1, `irq`=0. Read FF03 -> 8'hFF with `hit`=0.
- Loopback (`sin`=`sout`): write SB=8'hA5, then SC=8'h81 -> 8 falling edges on `sout` carrying 1,0,1,0,0,1,0,1. `irq` rises after 64 cycles. SB=8'hA5; SC reads 8'h7F.
- External clock, `sin` tied 1: SC=8'h80, SB=8'h3C, then 8 `sclk_in` pulses of 10 cycles high and 10 low -> `sout` shows 0,0,1,1,1,1,0,0. SB=8'hFF; `irq`=1; `sclk_oe`=0.
- Mid-transfer: after 3 bits, write SC=8'h01 -> state IDLE, no `irq`, `sclk_out`=1. A following SB write of 8'h12 reads back 8'h12.
- Ack race: assert `iack`=8'h08 on the completion cycle -> `irq` stays 1. The next `iack`=8'h08 clears it. `iack`=8'h04 has no effect.
- Assert `resetn`=0 during bit 5 -> all outputs at reset values without waiting for a `clk` edge.
